// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state/class encodings, opcode and ALU constants, ALU op helper
package multicycle_ctrl_pkg;
    typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
    typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ, C_ILL} cls_t;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    // alt selects SUB over ADD and SRA over SRL
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b100:  alu_op = ALU_XOR;
            3'b010:  alu_op = ALU_SLT;
            3'b001:  alu_op = ALU_SLL;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            default: alu_op = ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath control bundle
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        Zero;
    logic        dReady;
    logic        ALUSrc;
    logic [3:0]  ALUCtrl;
    logic        RegWrite;
    logic        MemToReg;
    logic        MemRead;
    logic        MemWrite;
    logic        loadPC;
    logic        PCSrc;
    modport master (input instr, Zero, dReady,
                    output ALUSrc, ALUCtrl, RegWrite, MemToReg, MemRead, MemWrite, loadPC, PCSrc);
    modport slave  (output instr, Zero, dReady,
                    input ALUSrc, ALUCtrl, RegWrite, MemToReg, MemRead, MemWrite, loadPC, PCSrc);
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: combinational instr -> ALU control, operand select, class and illegal flag
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src,
    output logic        illegal_dec,
    output cls_t        cls
);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic is_r, is_i, is_lw, is_sw, is_beq, bad;
    assign opc = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign is_r = opc == OP_R;
    assign is_i = opc == OP_I;
    assign is_lw = opc == OP_LW;
    assign is_sw = opc == OP_SW;
    assign is_beq = opc == OP_BEQ;
    assign bad = (is_beq && f3 != 3'b000) || ((is_lw || is_sw) && f3 != 3'b010) ||
                 (is_r && f7 != 7'd0 && f7 != F7_ALT) ||
                 (is_r && f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101);
    assign illegal_dec = !(is_r || is_i || is_lw || is_sw || is_beq) || bad;
    assign cls = illegal_dec ? C_ILL : is_r ? C_R : is_i ? C_I : is_lw ? C_LW : is_sw ? C_SW : C_BEQ;
    assign alu_ctrl = illegal_dec ? ALU_AND : is_r ? alu_op(f3, f7 == F7_ALT) :
                      is_i ? alu_op(f3, f3 == 3'b101 && instr[30]) : is_beq ? ALU_SUB : ALU_ADD;
    assign alu_src = !illegal_dec && (is_i || is_lw || is_sw);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB sequencer with branch latch, retire counter and sticky illegal flag
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.master bus,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);
    state_t st, nxt;
    cls_t   cls;
    logic   taken_q, ill_dec;
    alu_decoder u_dec (
        .instr(bus.instr), .alu_ctrl(bus.ALUCtrl), .alu_src(bus.ALUSrc),
        .illegal_dec(ill_dec), .cls(cls)
    );
    assign state = st;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S_IF;
            taken_q <= 1'b0;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            st <= nxt;
            taken_q <= st == S_EX ? cls == C_BEQ && bus.Zero : st == S_WB ? 1'b0 : taken_q;
            if (st == S_ID && ill_dec) illegal <= 1'b1;
            if (st == S_WB && !ill_dec) instret <= instret + CNT_W'(1);
        end
    end
    always_comb begin
        nxt = S_IF;
        bus.RegWrite = 1'b0;
        bus.MemToReg = 1'b0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.loadPC = 1'b0;
        bus.PCSrc = 1'b0;
        case (st)
            S_IF:  nxt = S_ID;
            S_ID:  nxt = ill_dec ? S_WB : S_EX;
            S_EX:  nxt = (cls == C_LW || cls == C_SW) ? S_MEM : S_WB;
            S_MEM: begin
                bus.MemRead = cls == C_LW;
                bus.MemWrite = cls == C_SW;
                nxt = bus.dReady ? S_WB : S_MEM;
            end
            S_WB: begin
                bus.loadPC = 1'b1;
                bus.PCSrc = taken_q;
                bus.RegWrite = cls == C_R || cls == C_I || cls == C_LW;
                bus.MemToReg = cls == C_LW;
            end
            default: nxt = S_IF;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instructions with a WB-triggered scoreboard monitor
module tb_multicycle_ctrl;
    logic clk = 1'b0, rst;
    logic [2:0] state;
    logic illegal;
    logic [2:0] instret;
    int errors = 0, checks = 0;
    int cyc = 0, rd = 0, wr = 0;
    logic stray = 1'b0;

    typedef struct {
        string nm;
        logic [3:0] alu;
        logic src, rw, m2r, pcs, ill;
        int cyc, rd, wr;
        logic [2:0] cnt;
    } exp_t;
    exp_t q[$];

    multicycle_ctrl_if bus();
    multicycle_ctrl #(.CNT_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus.master), .state(state), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0; rd = 0; wr = 0; stray = 1'b0;
        end else begin
            cyc++;
            rd += int'(bus.MemRead);
            wr += int'(bus.MemWrite);
            if (!bus.loadPC && (bus.RegWrite || bus.MemToReg || bus.PCSrc)) stray = 1'b1;
            if (bus.MemRead && bus.MemWrite) stray = 1'b1;
            if (bus.loadPC) begin
                if (q.size() == 0) chk("unexpected_wb", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.nm, ".alu"}, bus.ALUCtrl, e.alu);
                    chk({e.nm, ".src"}, bus.ALUSrc, e.src);
                    chk({e.nm, ".regwrite"}, bus.RegWrite, e.rw);
                    chk({e.nm, ".memtoreg"}, bus.MemToReg, e.m2r);
                    chk({e.nm, ".pcsrc"}, bus.PCSrc, e.pcs);
                    chk({e.nm, ".cycles"}, cyc, e.cyc);
                    chk({e.nm, ".memread_cycles"}, rd, e.rd);
                    chk({e.nm, ".memwrite_cycles"}, wr, e.wr);
                    chk({e.nm, ".instret"}, instret, e.cnt);
                    chk({e.nm, ".illegal"}, illegal, e.ill);
                    chk({e.nm, ".stray_strobe"}, stray, 0);
                end
                cyc = 0; rd = 0; wr = 0; stray = 1'b0;
            end
        end
    end

    task automatic run(input string nm, input logic [31:0] ins, input logic z, input int stalls,
                       input logic [3:0] alu, input logic src, rw, m2r, pcs, input int c, r, w,
                       input logic [2:0] cnt, input logic ill);
        q.push_back('{nm, alu, src, rw, m2r, pcs, ill, c, r, w, cnt});
        bus.instr = ins;
        bus.Zero = z;
        bus.dReady = stalls == 0;
        if (stalls > 0) begin
            for (int k = 0; k < 20 && state != 3'd3; k++) @(negedge clk);
            repeat (stalls) @(negedge clk);
            bus.dReady = 1'b1;
        end
        for (int k = 0; k < 40 && !bus.loadPC; k++) @(negedge clk);
        if (!bus.loadPC) chk({nm, ".timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.instr = 32'h0;
        bus.Zero = 1'b0;
        bus.dReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.state", state, 0);
        chk("rst.strobes", {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.loadPC}, 0);
        chk("rst.instret", instret, 0);
        chk("rst.illegal", illegal, 0);
        rst = 1'b0;
        @(negedge clk);
        //    name      instr         Z  st alu     src rw m2r pcs cyc rd wr cnt ill
        run("add",     32'h002081B3, 0, 0, 4'b0010, 0, 1, 0, 0, 4, 0, 0, 3'd0, 0);
        run("lw",      32'h0080A283, 0, 2, 4'b0010, 1, 1, 1, 0, 7, 3, 0, 3'd1, 0);
        run("beq_t",   32'h00208463, 1, 0, 4'b0110, 0, 0, 0, 1, 4, 0, 0, 3'd2, 0);
        run("beq_nt",  32'h00208463, 0, 0, 4'b0110, 0, 0, 0, 0, 4, 0, 0, 3'd3, 0);
        run("srai",    32'h4030D093, 0, 0, 4'b1010, 1, 1, 0, 0, 4, 0, 0, 3'd4, 0);
        run("sw",      32'h0020A423, 0, 1, 4'b0010, 1, 0, 0, 0, 6, 0, 2, 3'd5, 0);
        run("sub",     32'h402081B3, 0, 0, 4'b0110, 0, 1, 0, 0, 4, 0, 0, 3'd6, 0);
        run("ill_op",  32'h0000007F, 1, 0, 4'b0000, 0, 0, 0, 0, 3, 0, 0, 3'd7, 1);
        run("add2",    32'h002081B3, 0, 0, 4'b0010, 0, 1, 0, 0, 4, 0, 0, 3'd7, 1);
        run("ill_r",   32'h402091B3, 0, 0, 4'b0000, 0, 0, 0, 0, 3, 0, 0, 3'd0, 1);
        run("ill_beq", 32'h00209463, 1, 0, 4'b0000, 0, 0, 0, 0, 3, 0, 0, 3'd0, 1);
        run("add3",    32'h002081B3, 0, 0, 4'b0010, 0, 1, 0, 0, 4, 0, 0, 3'd0, 1);
        bus.instr = 32'h0080A283;
        bus.dReady = 1'b0;
        for (int k = 0; k < 20 && state != 3'd3; k++) @(negedge clk);
        chk("midmem.reached", state, 3);
        chk("midmem.memread", bus.MemRead, 1);
        rst = 1'b1;
        #1;
        chk("midmem.rst_state", state, 0);
        chk("midmem.rst_memread", bus.MemRead, 0);
        chk("midmem.rst_instret", instret, 0);
        chk("midmem.rst_illegal", illegal, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.dReady = 1'b1;
        @(negedge clk);
        run("add_post", 32'h002081B3, 0, 0, 4'b0010, 0, 1, 0, 0, 4, 0, 0, 3'd0, 0);
        chk("post.instret", instret, 1);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
